decoder_3to8: RTL and testbench

Registered 3-to-8 one-hot decoder. It converts a 3-bit binary select into an 8-bit one-hot output line vector, sampled on the clock. It sits on select/address paths that need a glitch-free, clock-aligned one-hot enable, such as bank or register-strobe selection. The optional enable and valid flag let the block drop into a pipelined control path.

---
 rtl/decoder_pkg.sv | 12 +
 rtl/decoder_3to8_comb.sv | 28 ++
 rtl/decoder_3to8.sv | 59 +++++
 tb/tb_decoder_3to8.sv | 131 +++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and constants for the registered 3-to-8 one-hot decoder.
package decoder_pkg;

  localparam int IN_W  = 3;
  localparam int OUT_W = 8;

  typedef logic [IN_W-1:0]  sel_t;
  typedef logic [OUT_W-1:0] onehot_t;

  localparam onehot_t DEC_IDLE = '0;

endpackage : decoder_pkg

// File: rtl/decoder_3to8_comb.sv
// Pure combinational binary-to-one-hot decode, active-high, gated by en.
// Unknown or disabled selects resolve to DEC_IDLE so X never reaches the flops.
module decoder_3to8_comb
  import decoder_pkg::*;
(
  input  logic [IN_W-1:0]  in,
  input  logic             en,
  output logic [OUT_W-1:0] out
);

  always_comb begin
    out = DEC_IDLE;
    if (en) begin
      case (in)
        3'd0:    out = 8'b0000_0001;
        3'd1:    out = 8'b0000_0010;
        3'd2:    out = 8'b0000_0100;
        3'd3:    out = 8'b0000_1000;
        3'd4:    out = 8'b0001_0000;
        3'd5:    out = 8'b0010_0000;
        3'd6:    out = 8'b0100_0000;
        3'd7:    out = 8'b1000_0000;
        default: out = DEC_IDLE;
      endcase
    end
  end

endmodule : decoder_3to8_comb

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 one-hot decoder with optional active-low output polarity.
// One cycle latency, one select per cycle; out is driven only from flops.
module decoder_3to8 #(
  parameter int IN_W       = 3,
  parameter int OUT_W      = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic             out_valid
);

  localparam logic [OUT_W-1:0] INACTIVE = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  logic [OUT_W-1:0] dec_w;
  logic [OUT_W-1:0] out_d;
  logic [OUT_W-1:0] out_q;
  logic             valid_d;
  logic             valid_q;

  decoder_3to8_comb u_comb (
    .in  (in),
    .en  (en),
    .out (dec_w)
  );

  // dec_w is already gated by en and idle on unknown selects, so any set bit
  // means a genuine decode happened this cycle.
  assign valid_d = |dec_w;
  assign out_d   = ACTIVE_LOW ? ~dec_w : dec_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= INACTIVE;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;

`ifndef SYNTHESIS
  logic [OUT_W-1:0] out_act;
  assign out_act = ACTIVE_LOW ? ~out_q : out_q;

  a_valid_onehot : assert property (@(posedge clk) disable iff (rst)
    valid_q |-> $onehot(out_act));

  a_idle_inactive : assert property (@(posedge clk) disable iff (rst)
    !valid_q |-> (out_act == decoder_pkg::DEC_IDLE));
`endif

endmodule : decoder_3to8

// File: tb/tb_decoder_3to8.sv
// Directed plus random bench for decoder_3to8, both polarities side by side.
module tb_decoder_3to8;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] sel;
  logic [7:0] out_ah;
  logic [7:0] out_al;
  logic       vld_ah;
  logic       vld_al;

  int n_vec;
  int n_miscompare;

  typedef struct packed {
    logic [7:0] o_hi;
    logic [7:0] o_lo;
    logic       v;
  } exp_t;

  exp_t sb[$];

  decoder_3to8 #(.ACTIVE_LOW(1'b0)) u_dut_ah (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in        (sel),
    .out       (out_ah),
    .out_valid (vld_ah)
  );

  decoder_3to8 #(.ACTIVE_LOW(1'b1)) u_dut_al (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in        (sel),
    .out       (out_al),
    .out_valid (vld_al)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_outputs(input string tag);
    exp_t x;
    assert (sb.size() != 0) else begin
      n_miscompare++;
      $error("FAIL %s sb_empty: queue size %0d, required nonzero", tag, sb.size());
    end
    if (sb.size() != 0) begin
      x = sb.pop_front();
      assert (out_ah === x.o_hi) else begin
        n_miscompare++;
        $error("FAIL %s out_hi: got %h, expected %h", tag, out_ah, x.o_hi);
      end
      assert (out_al === x.o_lo) else begin
        n_miscompare++;
        $error("FAIL %s out_lo: got %h, expected %h", tag, out_al, x.o_lo);
      end
      assert (vld_ah === x.v) else begin
        n_miscompare++;
        $error("FAIL %s valid_hi: got %b, expected %b", tag, vld_ah, x.v);
      end
      assert (vld_al === x.v) else begin
        n_miscompare++;
        $error("FAIL %s valid_lo: got %b, expected %b", tag, vld_al, x.v);
      end
    end
  endtask

  task automatic step(input string tag, input logic r, input logic e, input logic [2:0] s);
    exp_t x;
    logic  live;
    rst  = r;
    en   = e;
    sel  = s;
    live = !r && e && !$isunknown(s);
    x.v    = live;
    x.o_hi = live ? (8'h01 << s) : 8'h00;
    x.o_lo = ~x.o_hi;
    sb.push_back(x);
    n_vec++;
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    n_vec        = 0;
    n_miscompare = 0;
    rst          = 1'b1;
    en           = 1'b1;
    sel          = 3'd5;

    step("reset0", 1'b1, 1'b1, 3'd5);
    step("reset1", 1'b1, 1'b1, 3'd5);

    for (int i = 0; i < 8; i++) step("sweep", 1'b0, 1'b1, 3'(i));

    step("gate_on",  1'b0, 1'b1, 3'd3);
    step("gate_off", 1'b0, 1'b0, 3'd3);
    step("gate_off", 1'b0, 1'b0, 3'd3);
    step("gate_re",  1'b0, 1'b1, 3'd3);

    step("mid_a",   1'b0, 1'b1, 3'd4);
    step("mid_b",   1'b0, 1'b1, 3'd5);
    step("mid_rst", 1'b1, 1'b1, 3'd6);
    step("mid_rel", 1'b0, 1'b1, 3'd2);

    step("pol_0",   1'b0, 1'b1, 3'd0);
    step("pol_7",   1'b0, 1'b1, 3'd7);
    step("pol_dis", 1'b0, 1'b0, 3'd7);
    step("pol_rst", 1'b1, 1'b1, 3'd7);

    for (int i = 0; i < 5; i++) step("hold", 1'b0, 1'b1, 3'd4);

    step("x_sel",   1'b0, 1'b1, 3'bxxx);
    step("x_after", 1'b0, 1'b1, 3'd1);

    for (int i = 0; i < 40; i++)
      step("random", ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule : tb_decoder_3to8
